// File: rtl/lcd_update_scheduler.sv
// lcd_update_scheduler
// Queues CPU display requests (opcode, register index, signed value) in a
// circular FIFO. It hands them one at a time to the LCD controller over the
// lcd_update_req / lcd_busy handshake. After each completed update it keeps
// the message on screen for HOLD_CYCLES clocks.
//
// Optional build macro: LCD_SCHED_COALESCE_EN
//   When defined, a push that targets the same register index as the most
//   recently written, still-queued entry overwrites that entry in place.
//   The push is not appended.

module lcd_update_scheduler #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 25000000,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [2:0]                 push_opcode,
    input  logic [3:0]                 push_reg_idx,
    input  logic [15:0]                push_value,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 drop_cnt,
    output logic                       sched_busy,
    output logic                       lcd_update_req,
    output logic [2:0]                 lcd_opcode,
    output logic [3:0]                 lcd_reg_idx,
    output logic [15:0]                lcd_value,
    input  logic                       lcd_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } state_t;

    // Entry layout: {opcode[22:20], reg_idx[19:16], value[15:0]}
    logic [22:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic [7:0]    r_drop_cnt;

    state_t        r_state;
    logic          r_sched_busy;
    logic          r_lcd_update_req;
    logic [2:0]    r_lcd_opcode;
    logic [3:0]    r_lcd_reg_idx;
    logic [15:0]   r_lcd_value;
    logic [TW-1:0] r_ack_timer;
    logic [HW-1:0] r_hold_timer;

    logic          w_pop;
    logic          w_coalesce;
    logic          w_push_ok;
    logic          w_drop;
    logic [CW-1:0] w_count_nxt;
    logic [22:0]   w_push_entry;
    logic [22:0]   w_head_entry;
`ifdef LCD_SCHED_COALESCE_EN
    logic [AW-1:0] w_last_ptr;
`endif

    assign w_push_entry = {push_opcode, push_reg_idx, push_value};
    assign w_head_entry = r_mem[r_rd_ptr];

    // Pop, coalesce, accept/drop decisions and next occupancy
    always_comb begin
        w_pop       = 1'b0;
        w_coalesce  = 1'b0;
        w_push_ok   = 1'b0;
        w_drop      = 1'b0;
        w_count_nxt = r_count;
`ifdef LCD_SCHED_COALESCE_EN
        w_last_ptr  = r_wr_ptr - AW'(1);
`endif

        // The head leaves the FIFO only when the FSM issues it to an idle LCD.
        if ((r_state == ST_IDLE) && !r_empty && !lcd_busy) begin
            w_pop = 1'b1;
        end else begin
            w_pop = 1'b0;
        end

`ifdef LCD_SCHED_COALESCE_EN
        // The newest entry is the head when count==1. It cannot be rewritten
        // while it is being popped.
        if (push && !r_empty && !(w_pop && (r_count == CW'(1))) &&
            (r_mem[w_last_ptr][19:16] == push_reg_idx)) begin
            w_coalesce = 1'b1;
        end else begin
            w_coalesce = 1'b0;
        end
`else
        w_coalesce = 1'b0;
`endif

        // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
        if (push && !w_coalesce) begin
            if (!r_full || w_pop) begin
                w_push_ok = 1'b1;
            end else begin
                w_drop = 1'b1;
            end
        end else begin
            w_push_ok = 1'b0;
            w_drop    = 1'b0;
        end

        case ({w_push_ok, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage writes (appended or coalesced); data needs no reset
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_push_entry;
`ifdef LCD_SCHED_COALESCE_EN
        end else if (w_coalesce) begin
            r_mem[w_last_ptr] <= w_push_entry;
`endif
        end
    end

    // FIFO pointers, occupancy flags and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_drop_cnt <= 8'd0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == CW'(0));
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // Scheduler FSM: issue, wait for the LCD to acknowledge and finish, then hold the display
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_sched_busy     <= 1'b0;
            r_lcd_update_req <= 1'b0;
            r_lcd_opcode     <= 3'd0;
            r_lcd_reg_idx    <= 4'd0;
            r_lcd_value      <= 16'd0;
            r_ack_timer      <= '0;
            r_hold_timer     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_lcd_update_req <= 1'b0;
                    if (w_pop) begin
                        r_lcd_opcode     <= w_head_entry[22:20];
                        r_lcd_reg_idx    <= w_head_entry[19:16];
                        r_lcd_value      <= w_head_entry[15:0];
                        r_lcd_update_req <= 1'b1;
                        r_sched_busy     <= 1'b1;
                        r_state          <= ST_ISSUE;
                    end else begin
                        r_sched_busy <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    r_lcd_update_req <= 1'b0;
                    r_ack_timer      <= TW'(ACK_TIMEOUT);
                    r_state          <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (lcd_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_ack_timer == TW'(0)) begin
                        // No acknowledge: re-issue the same operands.
                        r_lcd_update_req <= 1'b1;
                        r_state          <= ST_ISSUE;
                    end else begin
                        r_ack_timer <= r_ack_timer - TW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!lcd_busy) begin
                        if (HOLD_CYCLES == 0) begin
                            r_sched_busy <= 1'b0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_hold_timer <= HW'(HOLD_CYCLES);
                            r_state      <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_hold_timer <= HW'(1)) begin
                        r_sched_busy <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_hold_timer <= r_hold_timer - HW'(1);
                    end
                end
                default: begin
                    r_lcd_update_req <= 1'b0;
                    r_sched_busy     <= 1'b0;
                    r_state          <= ST_IDLE;
                end
            endcase
        end
    end

    assign full           = r_full;
    assign empty          = r_empty;
    assign count          = r_count;
    assign drop_cnt       = r_drop_cnt;
    assign sched_busy     = r_sched_busy;
    assign lcd_update_req = r_lcd_update_req;
    assign lcd_opcode     = r_lcd_opcode;
    assign lcd_reg_idx    = r_lcd_reg_idx;
    assign lcd_value      = r_lcd_value;

endmodule
